// File: rtl/adder_ctrl_pkg.sv
// rtl/adder_ctrl_pkg.sv - shared types and constants for the nibble-serial adder
package adder_ctrl_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_slice4.sv
// rtl/adder_slice4.sv - combinational 4-bit ripple adder built from decoder-style full adders
module adder_slice4
    import adder_ctrl_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] s,
    output logic [NIBBLE-1:0] c
);

    // Each full adder decodes {a,b,cin} to one of 8 minterms and ORs the relevant ones.
    always_comb begin
        logic [7:0] m;
        logic       cy;
        m  = '0;
        cy = cin;
        s  = '0;
        c  = '0;
        for (int i = 0; i < NIBBLE; i++) begin
            m    = 8'b1 << {a[i], b[i], cy};
            s[i] = m[1] | m[2] | m[4] | m[7];
            cy   = m[3] | m[5] | m[6] | m[7];
            c[i] = cy;
        end
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add sequenced one nibble per cycle; `OVERFLOW_DETECT_EN adds ovf
module nibble_serial_adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef OVERFLOW_DETECT_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NSTEP = WIDTH / NIBBLE;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     step_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              c_out_q;
    logic [NIBBLE-1:0] sl_a, sl_b, sl_s, sl_c;
    logic              accept, last_step;

    assign accept    = in_valid & in_ready;
    assign last_step = (state_q == RUN) && (step_q == LAST_STEP);

    // The single shared slice sees the nibble selected by the step counter.
    assign sl_a = a_q[NIBBLE*step_q +: NIBBLE];
    assign sl_b = b_q[NIBBLE*step_q +: NIBBLE];

    adder_slice4 u_slice (
        .a   (sl_a),
        .b   (sl_b),
        .cin (carry_q),
        .s   (sl_s),
        .c   (sl_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q  <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            step_q  <= '0;
        end else if (state_q == RUN) begin
            sum_q[NIBBLE*step_q +: NIBBLE] <= sl_s;
            carry_q                        <= sl_c[NIBBLE-1];
            if (last_step) c_out_q <= sl_c[NIBBLE-1];
            else           step_q  <= step_q + 1'b1;
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q;

    // Signed overflow: carry out of the MSB differs from carry into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ovf_q <= 1'b0;
        else if (accept)    ovf_q <= 1'b0;
        else if (last_step) ovf_q <= sl_c[NIBBLE-1] ^ sl_c[NIBBLE-2];
    end

    assign ovf = ovf_q;
`endif

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed vector table plus handshake, reset and random sequences
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        busy;
    logic        ovf;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
`ifdef OVERFLOW_DETECT_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

`ifndef OVERFLOW_DETECT_EN
    assign ovf = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, hold the result for `stall` cycles, then hand it off.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                          input int stall, input bit junk,
                          output logic [15:0] rs, output logic rc, output logic ro,
                          output int lat);
        int n;
        a = ta; b = tbv; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) begin
            nchecks++; nerrors++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            if (junk) begin
                a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            nchecks++; nerrors++;
            $display("FAIL done_timeout: out_valid=%b expected 1", out_valid);
        end
        for (int i = 0; i < stall; i++) tick();
        rs = sum; rc = c_out; ro = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_clear", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] rs;
        logic        rc, ro;
        logic [16:0] exp17;
        logic        exp_ovf;
        int          lat;
        int          n;
        int          results;
        bit          seen;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        #1;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_sum",       {16'b0, sum},       32'd0);
        check("rst_c_out",     {31'b0, c_out},     32'd0);
        check("rst_ovf",       {31'b0, ovf},       32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1, 1'b0, rs, rc, ro, lat);
            check($sformatf("vec%0d_sum", i),  {16'b0, rs}, {16'b0, vecs[i].sum});
            check($sformatf("vec%0d_cout", i), {31'b0, rc}, {31'b0, vecs[i].cout});
            check($sformatf("vec%0d_lat", i),  32'(lat), 32'd5);
`ifdef OVERFLOW_DETECT_EN
            check($sformatf("vec%0d_ovf", i),  {31'b0, ro}, {31'b0, vecs[i].ovf});
`endif
        end

        // out_ready high ahead of DONE: out_valid still appears for a cycle
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("early_ready_lat", 32'(lat), 32'd5);
        check("early_ready_sum", {16'b0, sum}, 32'h2345);
        tick();
        out_ready = 1'b0;
        check("early_ready_handoff", {31'b0, out_valid}, 32'd0);

        // DONE stall with a competing new operand
        a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        a = 16'h0505; b = 16'h0A0A; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_sum",   {16'b0, sum},       32'h3333);
            check("stall_ready", {31'b0, in_ready},  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_idle_valid", {31'b0, out_valid}, 32'd0);
        check("stall_idle_ready", {31'b0, in_ready},  32'd1);
        tick();
        in_valid = 1'b0;
        check("stall_new_busy", {31'b0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("stall_new_sum", {16'b0, sum}, 32'h0F0F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of RUN
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_busy",      {31'b0, busy},      32'd0);
        check("midrst_sum",       {16'b0, sum},       32'd0);
        check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("midrst_no_result", {31'b0, seen}, 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, rs, rc, ro, lat);
        check("midrst_next_sum", {16'b0, rs}, 32'h0100);

        // Random operands, gaps and stalls, junk on inputs while busy
        results = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            logic        rcin;
            ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            run_op(ra, rb, rcin, $urandom_range(0, 3), 1'b1, rs, rc, ro, lat);
            results++;
            exp17   = {1'b0, ra} + {1'b0, rb} + {16'b0, rcin};
            exp_ovf = (ra[15] == rb[15]) && (exp17[15] != ra[15]);
            check("rand_result", {15'b0, rc, rs}, {15'b0, exp17});
`ifdef OVERFLOW_DETECT_EN
            check("rand_ovf", {31'b0, ro}, {31'b0, exp_ovf});
`endif
        end
        check("rand_count", 32'(results), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
